// File: rtl/phy_tx_serializer_if.sv
// Lane-side bundle of the 4-lane PHY transmit serializer: parallel lanes with valids in,
// serial stream, frame marker, run status and valid-byte counter out.
interface phy_tx_serializer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       in0;
    logic [7:0]       in1;
    logic [7:0]       in2;
    logic [7:0]       in3;
    logic             val_in0;
    logic             val_in1;
    logic             val_in2;
    logic             val_in3;
    logic             data_out;
    logic             frame_start;
    logic             tx_active;
    logic [CNT_W-1:0] byte_cnt;

    modport master (
        output in0, in1, in2, in3,
        output val_in0, val_in1, val_in2, val_in3,
        input  data_out, frame_start, tx_active, byte_cnt
    );

    modport slave (
        input  in0, in1, in2, in3,
        input  val_in0, val_in1, val_in2, val_in3,
        output data_out, frame_start, tx_active, byte_cnt
    );
endinterface

// File: rtl/phy_tx_serializer.sv
// 4-lane PHY transmit serializer: one capture per 32-cycle frame, MSB-first bit stream on clk_32f.
// Optional training phase of TRAIN_FRAMES all-COMMA frames is enabled by defining PHY_TX_TRAIN_EN.
module phy_tx_serializer #(
    parameter logic [7:0] COMMA        = 8'hBC,
`ifdef PHY_TX_TRAIN_EN
    parameter int         TRAIN_FRAMES = 4,
`endif
    parameter int         CNT_W        = 16
) (
    input  logic                 clk_32f,
    input  logic                 rst,
    phy_tx_serializer_if.slave   bus
);

    logic [4:0]       cnt_q, cnt_d;
    logic [7:0]       cap_q [4];
    logic [7:0]       cap_d [4];
    logic             data_out_q, data_out_d;
    logic             frame_start_q, frame_start_d;
    logic             tx_active_q, tx_active_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]       bit_idx;
    logic [2:0]       n_valid;
    logic             capture;
    logic             run;

    assign capture = (cnt_q == 5'd31);
    assign bit_idx = 3'd7 - cnt_q[2:0];
    assign n_valid = {2'b00, bus.val_in0} + {2'b00, bus.val_in1}
                   + {2'b00, bus.val_in2} + {2'b00, bus.val_in3};

`ifdef PHY_TX_TRAIN_EN
    // state   | meaning
    // S_TRAIN | sending all-COMMA frames so the receiver can lock, lane inputs ignored
    // S_RUN   | lanes captured each frame, held until rst
    typedef enum logic {S_TRAIN, S_RUN} state_e;

    localparam int TC_W = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;

    state_e            state_q, state_d;
    logic [TC_W-1:0]   train_cnt_q, train_cnt_d;

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state_q     <= S_TRAIN;
            train_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        tx_active_d = tx_active_q;
        if (state_q == S_TRAIN && capture) begin
            train_cnt_d = train_cnt_q + 1'b1;
            if (train_cnt_q == TC_W'(TRAIN_FRAMES - 1)) begin
                state_d     = S_RUN;
                tx_active_d = 1'b1;
            end
        end
    end

    assign run = (state_q == S_RUN);
`else
    assign run         = 1'b1;
    assign tx_active_d = 1'b1;
`endif

    always_comb begin
        cnt_d         = cnt_q + 5'd1;
        data_out_d    = cap_q[cnt_q[4:3]][bit_idx];
        frame_start_d = (cnt_q == 5'd0);
        cap_d         = cap_q;
        byte_cnt_d    = byte_cnt_q;
        if (capture) begin
            if (run) begin
                cap_d[0]   = bus.val_in0 ? bus.in0 : COMMA;
                cap_d[1]   = bus.val_in1 ? bus.in1 : COMMA;
                cap_d[2]   = bus.val_in2 ? bus.in2 : COMMA;
                cap_d[3]   = bus.val_in3 ? bus.in3 : COMMA;
                // plain modulo add, the counter wraps rather than saturating
                byte_cnt_d = byte_cnt_q + CNT_W'(n_valid);
            end else begin
                for (int i = 0; i < 4; i++) cap_d[i] = COMMA;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            cnt_q         <= '0;
            for (int i = 0; i < 4; i++) cap_q[i] <= COMMA;
            data_out_q    <= 1'b0;
            frame_start_q <= 1'b0;
            tx_active_q   <= 1'b0;
            byte_cnt_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            cap_q         <= cap_d;
            data_out_q    <= data_out_d;
            frame_start_q <= frame_start_d;
            tx_active_q   <= tx_active_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.frame_start = frame_start_q;
    assign bus.tx_active   = tx_active_q;
    assign bus.byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: frame scoreboard on the serial stream plus byte counter models
// for a 16-bit and a 4-bit counter instance driven with identical lanes.
module tb_phy_tx_serializer;
    localparam logic [7:0]  COMMA  = 8'hBC;
    localparam logic [31:0] COMMA4 = {4{8'hBC}};
`ifdef PHY_TX_TRAIN_EN
    localparam int RUN_FROM = 4;
`else
    localparam int RUN_FROM = 0;
`endif

    logic clk_32f = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_32f = ~clk_32f;

    phy_tx_serializer_if #(.CNT_W(16)) if16 ();
    phy_tx_serializer_if #(.CNT_W(4))  if4  ();

    phy_tx_serializer #(.CNT_W(16)) dut16 (.clk_32f(clk_32f), .rst(rst), .bus(if16.slave));
    phy_tx_serializer #(.CNT_W(4))  dut4  (.clk_32f(clk_32f), .rst(rst), .bus(if4.slave));

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    int          frame_idx;
    logic [15:0] exp_cnt16;
    logic [3:0]  exp_cnt4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [3:0] v);
        if16.in0 = d0; if16.in1 = d1; if16.in2 = d2; if16.in3 = d3;
        if4.in0  = d0; if4.in1  = d1; if4.in2  = d2; if4.in3  = d3;
        {if16.val_in3, if16.val_in2, if16.val_in1, if16.val_in0} = v;
        {if4.val_in3,  if4.val_in2,  if4.val_in1,  if4.val_in0}  = v;
    endtask

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(COMMA4);
        frame_idx = 0;
        exp_cnt16 = '0;
        exp_cnt4  = '0;
    endtask

    // Runs one 32-edge frame starting with pre-edge phase 0; lanes are garbage until edge 19
    // and hold d0..d3/v through the capture edge (edge 32).
    task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [3:0] v);
        logic [31:0] got;
        logic [31:0] exp;
        logic [31:0] nxt;
        logic        run;
        logic        exp_tx;
        got = '0;
        for (int k = 1; k <= 32; k++) begin
            step();
            got = {got[30:0], if16.data_out};
            exp_tx = (frame_idx >= RUN_FROM) || (frame_idx == RUN_FROM - 1 && k == 32);
            if (k == 1) chk("frame_start_hi", 32'(if16.frame_start), 32'd1);
            if (k == 2) chk("frame_start_lo", 32'(if16.frame_start), 32'd0);
            if (k == 1 || k == 32) chk("tx_active", 32'(if16.tx_active), 32'(exp_tx));
            if (k < 19)
                set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           4'($urandom_range(0, 15)));
            else if (k == 19)
                set_inputs(d0, d1, d2, d3, v);
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("serial_frame", got, exp);
        end
        run = (frame_idx >= RUN_FROM);
        nxt = {(run && v[0]) ? d0 : COMMA, (run && v[1]) ? d1 : COMMA,
               (run && v[2]) ? d2 : COMMA, (run && v[3]) ? d3 : COMMA};
        exp_q.push_back(nxt);
        if (run) begin
            exp_cnt16 = exp_cnt16 + 16'($countones(v));
            exp_cnt4  = exp_cnt4  + 4'($countones(v));
        end
        chk("byte_cnt16", 32'(if16.byte_cnt), 32'(exp_cnt16));
        chk("byte_cnt4",  32'(if4.byte_cnt),  32'(exp_cnt4));
        frame_idx++;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data_out"},    32'(if16.data_out),    32'd0);
        chk({tag, "_frame_start"}, 32'(if16.frame_start), 32'd0);
        chk({tag, "_tx_active"},   32'(if16.tx_active),   32'd0);
        chk({tag, "_byte_cnt16"},  32'(if16.byte_cnt),    32'd0);
        chk({tag, "_byte_cnt4"},   32'(if4.byte_cnt),     32'd0);
    endtask

    // Advances n edges into the current frame, then applies rst on the following edge.
    task automatic do_reset(input int n_into, input string tag);
        for (int k = 0; k < n_into; k++) step();
        rst = 1'b1;
        step();
        check_reset_state(tag);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        repeat (3) step();
        check_reset_state("por");
        rst = 1'b0;
        model_reset();

        repeat (5) frame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        repeat (2) frame(8'h01, 8'h02, 8'h03, 8'hFF, 4'b1111);
        repeat (2) frame(8'hA5, 8'h77, 8'h3C, 8'h5A, 4'b1101);
        repeat (4) frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);

        do_reset(17, "rst_mid");
        repeat (5) frame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 4'b1111);
        frame(8'hC3, 8'h96, 8'h0F, 8'hF0, 4'b1010);

        set_inputs(8'h55, 8'h66, 8'h77, 8'h88, 4'b1111);
        do_reset(31, "rst_capture");
        frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        repeat (RUN_FROM) frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        frame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
